axil_fifo_mm_bridge: RTL and testbench

//  AXI-Lite slave mapping num_slots_p register windows onto pairs of small FIFOs (host->device tx,

---
 rtl/axil_fifo_mm_bridge.sv | 254 +++++++++++++++++++++++++
 tb/tb_axil_fifo_mm_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_fifo_mm_bridge.sv
// AXI-Lite slave that exposes num_slots_p register windows, each backed by a
// host->device tx fifo and a device->host rx fifo, plus one read-only
// monitor/ROM window placed directly after the last slot window.

package axil_fifo_mm_bridge_pkg;
  typedef struct packed {
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } axil_mosi_s;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
  } axil_miso_s;
endpackage

module axil_fifo_mm_bridge
  import axil_fifo_mm_bridge_pkg::*;
#(
  parameter logic [31:0] base_addr_p       = 32'h0,
  parameter int          num_slots_p       = 2,
  parameter int          fifo_els_p        = 4,
  parameter int          fifo_width_p      = 32,
  parameter int          base_addr_width_p = 8,
  parameter logic [7:0]  ofs_rsp_vac_p     = 8'hF0,
  parameter logic [7:0]  ofs_req_vac_p     = 8'hF4,
  parameter logic [7:0]  ofs_credits_p     = 8'hF8
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  axil_mosi_s                               s_axil_bus_i,
  output axil_miso_s                               s_axil_bus_o,
  output logic [num_slots_p-1:0]                   fifo_v_o,
  output logic [num_slots_p-1:0][fifo_width_p-1:0] fifo_data_o,
  input  logic [num_slots_p-1:0]                   fifo_rdy_i,
  input  logic [num_slots_p-1:0]                   fifo_v_i,
  input  logic [num_slots_p-1:0][fifo_width_p-1:0] fifo_data_i,
  output logic [num_slots_p-1:0]                   fifo_rdy_o,
  output logic [31:0]                              rom_addr_o,
  input  logic [31:0]                              rom_data_i,
  input  logic [num_slots_p-1:0][31:0]             rcv_vacancy_i,
  input  logic [num_slots_p/2-1:0][31:0]           mc_out_credits_i
);

  localparam int ofs_w = base_addr_width_p;
  localparam int win_w = 32 - base_addr_width_p;
  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam int ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int idx_w = $clog2(num_slots_p);
  localparam logic [win_w-1:0] win_base = win_w'(base_addr_p >> base_addr_width_p);
  localparam logic [ofs_w-1:0] ofs_isr  = ofs_w'(8'h00);
  localparam logic [ofs_w-1:0] ofs_tdfv = ofs_w'(8'h0C);
  localparam logic [ofs_w-1:0] ofs_tdr  = ofs_w'(8'h10);
  localparam logic [ofs_w-1:0] ofs_rdfo = ofs_w'(8'h1C);
  localparam logic [ofs_w-1:0] ofs_rdr  = ofs_w'(8'h20);
  localparam logic [ofs_w-1:0] ofs_rlr  = ofs_w'(8'h24);

  if (num_slots_p < 2 || fifo_width_p != 32) begin : g_param_check
    $fatal(1, "axil_fifo_mm_bridge: needs num_slots_p >= 2 and fifo_width_p == 32");
  end

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e w_state, w_next;
  r_state_e r_state, r_next;
  logic [31:0] w_addr, r_addr;
  logic [num_slots_p-1:0] w_slot_oh, r_slot_oh;
  logic r_mon_hit;
  logic [idx_w-1:0] r_idx;
  logic [ofs_w-1:0] w_ofs, r_ofs;
  logic w_fire, r_fire;
  logic [num_slots_p-1:0] tx_enq, tx_deq, rx_enq, rx_deq, isr_clr, isr;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;

  logic [fifo_width_p-1:0] tx_mem [num_slots_p][fifo_els_p];
  logic [fifo_width_p-1:0] rx_mem [num_slots_p][fifo_els_p];
  logic [ptr_w-1:0] tx_wp [num_slots_p];
  logic [ptr_w-1:0] tx_rp [num_slots_p];
  logic [ptr_w-1:0] rx_wp [num_slots_p];
  logic [ptr_w-1:0] rx_rp [num_slots_p];
  logic [cnt_w-1:0] tx_cnt [num_slots_p];
  logic [cnt_w-1:0] rx_cnt [num_slots_p];

  logic unused_bits;
  assign unused_bits = ^{s_axil_bus_i.awprot, s_axil_bus_i.wstrb, s_axil_bus_i.arprot};

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(fifo_els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  // State registers for both AXI channels; addresses are captured in ADDR
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_addr  <= '0;
      r_addr  <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (w_state == W_ADDR) w_addr <= s_axil_bus_i.awaddr;
      if (r_state == R_ADDR) r_addr <= s_axil_bus_i.araddr;
    end
  end

  // Next-state logic: aw then w then b, and ar then r, strictly serialised
  always_comb begin
    w_next = w_state;
    r_next = r_state;
    unique case (w_state)
      W_IDLE:  if (s_axil_bus_i.awvalid) w_next = W_ADDR;
      W_ADDR:  w_next = W_DATA;
      W_DATA:  if (s_axil_bus_i.wvalid) w_next = W_RESP;
      W_RESP:  if (s_axil_bus_i.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    unique case (r_state)
      R_IDLE:  if (s_axil_bus_i.arvalid) r_next = R_ADDR;
      R_ADDR:  r_next = R_DATA;
      R_DATA:  if (s_axil_bus_i.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Window decode of the latched addresses into one-hot slot hits and a read index
  always_comb begin
    w_slot_oh = '0;
    r_slot_oh = '0;
    r_idx     = '0;
    for (int n = 0; n < num_slots_p; n++) begin
      w_slot_oh[n] = (w_addr[31:base_addr_width_p] == win_base + win_w'(n));
      r_slot_oh[n] = (r_addr[31:base_addr_width_p] == win_base + win_w'(n));
      if (r_slot_oh[n]) r_idx = r_idx | idx_w'(n);
    end
  end

  assign r_mon_hit = (r_addr[31:base_addr_width_p] == win_base + win_w'(num_slots_p));
  assign w_ofs     = w_addr[ofs_w-1:0];
  assign r_ofs     = r_addr[ofs_w-1:0];
  assign w_fire    = (w_state == W_DATA) && s_axil_bus_i.wvalid;
  assign r_fire    = (r_state == R_DATA) && s_axil_bus_i.rready;
  assign rom_addr_o = r_addr;

  // Per-slot fifo handshakes; a full fifo refuses even if it is being drained
  always_comb begin
    tx_enq   = '0;
    tx_deq   = '0;
    rx_enq   = '0;
    rx_deq   = '0;
    isr_clr  = '0;
    fifo_v_o = '0;
    fifo_rdy_o  = '0;
    fifo_data_o = '0;
    for (int n = 0; n < num_slots_p; n++) begin
      fifo_v_o[n]    = (tx_cnt[n] != '0);
      fifo_data_o[n] = tx_mem[n][tx_rp[n]];
      fifo_rdy_o[n]  = (rx_cnt[n] != cnt_w'(fifo_els_p));
      tx_deq[n]  = fifo_v_o[n] && fifo_rdy_i[n];
      rx_enq[n]  = fifo_v_i[n] && fifo_rdy_o[n];
      tx_enq[n]  = w_fire && w_slot_oh[n] && (w_ofs == ofs_tdr) &&
                   (tx_cnt[n] != cnt_w'(fifo_els_p));
      isr_clr[n] = w_fire && w_slot_oh[n] && (w_ofs == ofs_isr) && s_axil_bus_i.wdata[27];
      rx_deq[n]  = r_fire && r_slot_oh[n] && (r_ofs == ofs_rdr) && (rx_cnt[n] != '0);
    end
  end

  // Fifo storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < num_slots_p; n++) begin
      if (tx_enq[n]) tx_mem[n][tx_wp[n]] <= fifo_width_p'(s_axil_bus_i.wdata);
      if (rx_enq[n]) rx_mem[n][rx_wp[n]] <= fifo_data_i[n];
    end
  end

  // Fifo pointers, occupancy counters and the sticky tx-done ISR bit
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      isr <= '0;
      for (int n = 0; n < num_slots_p; n++) begin
        tx_wp[n]  <= '0;
        tx_rp[n]  <= '0;
        rx_wp[n]  <= '0;
        rx_rp[n]  <= '0;
        tx_cnt[n] <= '0;
        rx_cnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < num_slots_p; n++) begin
        if (tx_enq[n]) tx_wp[n] <= ptr_inc(tx_wp[n]);
        if (tx_deq[n]) tx_rp[n] <= ptr_inc(tx_rp[n]);
        if (rx_enq[n]) rx_wp[n] <= ptr_inc(rx_wp[n]);
        if (rx_deq[n]) rx_rp[n] <= ptr_inc(rx_rp[n]);
        tx_cnt[n] <= tx_cnt[n] + cnt_w'(tx_enq[n]) - cnt_w'(tx_deq[n]);
        rx_cnt[n] <= rx_cnt[n] + cnt_w'(rx_enq[n]) - cnt_w'(rx_deq[n]);
        if (tx_enq[n])       isr[n] <= 1'b1;
        else if (isr_clr[n]) isr[n] <= 1'b0;
      end
    end
  end

  // Read data mux driven purely by the latched read address
  always_comb begin
    rd_data = 32'hBEEF_DEAD;
    rd_resp = 2'b11;
    if (|r_slot_oh) begin
      rd_resp = 2'b00;
      case (r_ofs)
        ofs_isr:  rd_data = {4'b0, isr[r_idx], 27'b0};
        ofs_tdfv: rd_data = 32'(fifo_els_p) - 32'(tx_cnt[r_idx]);
        ofs_rdfo: rd_data = 32'(rx_cnt[r_idx]) & ~32'h3;
        ofs_rlr:  rd_data = (32'(rx_cnt[r_idx]) >= 32'd4) ? 32'd16 : 32'd0;
        ofs_rdr:  rd_data = 32'(rx_mem[r_idx][rx_rp[r_idx]]);
        default:  rd_data = 32'hBEEF_DEAD;
      endcase
    end else if (r_mon_hit) begin
      rd_resp = 2'b00;
      if (r_ofs == ofs_w'(ofs_rsp_vac_p))      rd_data = rcv_vacancy_i[0];
      else if (r_ofs == ofs_w'(ofs_req_vac_p)) rd_data = rcv_vacancy_i[1];
      else if (r_ofs == ofs_w'(ofs_credits_p)) rd_data = mc_out_credits_i[0];
      else                                     rd_data = rom_data_i;
    end
  end

  // AXI-Lite slave outputs decoded from the channel states
  always_comb begin
    s_axil_bus_o         = '0;
    s_axil_bus_o.awready = (w_state == W_ADDR);
    s_axil_bus_o.wready  = (w_state == W_DATA);
    s_axil_bus_o.bvalid  = (w_state == W_RESP);
    s_axil_bus_o.bresp   = (w_state == W_RESP && !(|w_slot_oh)) ? 2'b11 : 2'b00;
    s_axil_bus_o.arready = (r_state == R_ADDR);
    s_axil_bus_o.rvalid  = (r_state == R_DATA);
    s_axil_bus_o.rresp   = (r_state == R_DATA) ? rd_resp : 2'b00;
    s_axil_bus_o.rdata   = (r_state == R_DATA) ? rd_data : 32'h0;
  end

endmodule

// File: tb/tb_axil_fifo_mm_bridge.sv
// Self-checking bench for axil_fifo_mm_bridge: directed scenarios, then random
// AXI-Lite traffic with random fifo-side activity against a queue-based model.

module tb_axil_fifo_mm_bridge;
  import axil_fifo_mm_bridge_pkg::*;

  localparam int          N    = 2;
  localparam int          ELS  = 4;
  localparam logic [31:0] BASE = 32'h0004_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  axil_mosi_s bus_i;
  axil_miso_s bus_o;
  logic [N-1:0]         fifo_v_o, fifo_rdy_i, fifo_v_i, fifo_rdy_o;
  logic [N-1:0][31:0]   fifo_data_o, fifo_data_i;
  logic [31:0]          rom_addr, rom_data;
  logic [N-1:0][31:0]   rcv_vac;
  logic [N/2-1:0][31:0] credits;

  int checks = 0;
  int errors = 0;

  logic [31:0] txq [N][$];
  logic [31:0] rxq [N][$];
  logic        m_isr [N];
  logic [31:0] m_waddr, m_raddr;

  axil_fifo_mm_bridge #(
    .base_addr_p(BASE), .num_slots_p(N), .fifo_els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .s_axil_bus_i(bus_i), .s_axil_bus_o(bus_o),
    .fifo_v_o(fifo_v_o), .fifo_data_o(fifo_data_o), .fifo_rdy_i(fifo_rdy_i),
    .fifo_v_i(fifo_v_i), .fifo_data_i(fifo_data_i), .fifo_rdy_o(fifo_rdy_o),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .rcv_vacancy_i(rcv_vac), .mc_out_credits_i(credits)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] rdy, input logic [N-1:0] v,
                               input logic [N-1:0][31:0] d);
    fifo_rdy_i  = rdy;
    fifo_v_i    = v;
    fifo_data_i = d;
  endtask

  function automatic logic [31:0] win_rel(input logic [31:0] a);
    return (a >> 8) - (BASE >> 8);
  endfunction

  // Expected read result from the model; known=0 when the data is unspecified
  task automatic modelRead(input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output logic known);
    logic [31:0] rel;
    logic [7:0]  ofs;
    rel = win_rel(a);
    ofs = a[7:0];
    known = 1'b1;
    resp  = 2'b00;
    data  = 32'hBEEF_DEAD;
    if (rel < N) begin
      case (ofs)
        8'h00: data = m_isr[rel] ? 32'h0800_0000 : 32'h0;
        8'h0C: data = ELS - rxq[0].size() * 0 - txq[rel].size();
        8'h1C: data = rxq[rel].size() & ~32'h3;
        8'h24: data = (rxq[rel].size() >= 4) ? 32'd16 : 32'd0;
        8'h20: if (rxq[rel].size() > 0) data = rxq[rel][0]; else known = 1'b0;
        default: data = 32'hBEEF_DEAD;
      endcase
    end else if (rel == N) begin
      case (ofs)
        8'hF0:   data = rcv_vac[0];
        8'hF4:   data = rcv_vac[1];
        8'hF8:   data = credits[0];
        default: data = rom_data;
      endcase
    end else begin
      resp = 2'b11;
    end
  endtask

  logic [31:0] mon_rel, mon_data;
  logic [1:0]  mon_resp;
  logic        mon_known;
  logic [N-1:0] mon_txpush, mon_rxpop, mon_rxpush;

  // Compare process: checks DUT outputs against the model, then advances the
  // model by what the next rising edge will do
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < N; n++) begin
        txq[n].delete();
        rxq[n].delete();
        m_isr[n] = 1'b0;
      end
      checkOutput("reset_handshakes",
                  {27'b0, bus_o.awready, bus_o.wready, bus_o.bvalid, bus_o.arready, bus_o.rvalid}, 32'h0);
      checkOutput("reset_resps", {28'b0, bus_o.bresp, bus_o.rresp}, 32'h0);
      checkOutput("reset_tx_valid", 32'(fifo_v_o), 32'h0);
      checkOutput("reset_rx_ready", 32'(fifo_rdy_o), 32'(2'b11));
    end else begin
      mon_txpush = '0;
      mon_rxpop  = '0;
      mon_rxpush = '0;
      for (int n = 0; n < N; n++) begin
        checkOutput($sformatf("tx%0d_valid", n), 32'(fifo_v_o[n]), 32'(txq[n].size() != 0));
        if (txq[n].size() != 0)
          checkOutput($sformatf("tx%0d_data", n), fifo_data_o[n], txq[n][0]);
        checkOutput($sformatf("rx%0d_ready", n), 32'(fifo_rdy_o[n]), 32'(rxq[n].size() < ELS));
      end
      if (bus_i.arvalid && bus_o.arready) m_raddr = bus_i.araddr;
      if (bus_o.rvalid && bus_i.rready) begin
        modelRead(m_raddr, mon_data, mon_resp, mon_known);
        checkOutput("rresp", 32'(bus_o.rresp), 32'(mon_resp));
        if (mon_known) checkOutput("rdata", bus_o.rdata, mon_data);
        checkOutput("rom_addr", rom_addr, m_raddr);
        mon_rel = win_rel(m_raddr);
        if (mon_rel < N && m_raddr[7:0] == 8'h20 && rxq[mon_rel].size() > 0) mon_rxpop[mon_rel] = 1'b1;
      end
      if (bus_i.awvalid && bus_o.awready) m_waddr = bus_i.awaddr;
      if (bus_i.wvalid && bus_o.wready) begin
        mon_rel = win_rel(m_waddr);
        if (mon_rel < N) begin
          if (m_waddr[7:0] == 8'h10 && txq[mon_rel].size() < ELS) mon_txpush[mon_rel] = 1'b1;
          if (m_waddr[7:0] == 8'h00 && bus_i.wdata[27]) m_isr[mon_rel] = 1'b0;
        end
      end
      if (bus_o.bvalid && bus_i.bready)
        checkOutput("bresp", 32'(bus_o.bresp), (win_rel(m_waddr) < N) ? 32'h0 : 32'h3);
      for (int n = 0; n < N; n++) begin
        if (fifo_v_i[n] && rxq[n].size() < ELS) mon_rxpush[n] = 1'b1;
        if (txq[n].size() != 0 && fifo_rdy_i[n]) void'(txq[n].pop_front());
        if (mon_txpush[n]) begin
          txq[n].push_back(bus_i.wdata);
          m_isr[n] = 1'b1;
        end
        if (mon_rxpop[n])  void'(rxq[n].pop_front());
        if (mon_rxpush[n]) rxq[n].push_back(fifo_data_i[n]);
      end
    end
  end

  task automatic waitFlag(input string name, input int which);
    int t;
    logic f;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      case (which)
        0: f = bus_o.awready;
        1: f = bus_o.wready;
        2: f = bus_o.bvalid;
        3: f = bus_o.arready;
        default: f = bus_o.rvalid;
      endcase
    end while (!f && t < 20);
    checkOutput(name, 32'(f), 32'h1);
  endtask

  task automatic axilWrite(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    @(posedge clk); #1;
    bus_i.awaddr = addr; bus_i.awvalid = 1'b1;
    waitFlag("awready_seen", 0);
    @(posedge clk); #1;
    bus_i.awvalid = 1'b0; bus_i.wdata = data; bus_i.wvalid = 1'b1;
    waitFlag("wready_seen", 1);
    @(posedge clk); #1;
    bus_i.wvalid = 1'b0; bus_i.bready = 1'b1;
    waitFlag("bvalid_seen", 2);
    resp = bus_o.bresp;
    @(posedge clk); #1;
    bus_i.bready = 1'b0;
  endtask

  task automatic axilRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    @(posedge clk); #1;
    bus_i.araddr = addr; bus_i.arvalid = 1'b1;
    waitFlag("arready_seen", 3);
    @(posedge clk); #1;
    bus_i.arvalid = 1'b0; bus_i.rready = 1'b1;
    waitFlag("rvalid_seen", 4);
    data = bus_o.rdata;
    resp = bus_o.rresp;
    @(posedge clk); #1;
    bus_i.rready = 1'b0;
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  logic [7:0]  ofs_list [10];
  logic [31:0] addr;
  int          slot;

  initial begin
    bus_i = '0;
    applyStimulus('0, '0, '0);
    rom_data   = 32'h1234_5678;
    rcv_vac[0] = 32'h0000_00AB;
    rcv_vac[1] = 32'h0000_00CD;
    credits[0] = 32'h0000_0077;
    ofs_list = '{8'h00, 8'h0C, 8'h1C, 8'h24, 8'h20, 8'hF0, 8'hF4, 8'hF8, 8'h10, 8'h44};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] single TDR write to slot 0");
    axilRead(BASE + 32'h0C, d, r);  checkOutput("reset_tdfv0", d, 32'd4);
    axilWrite(BASE + 32'h10, 32'hA5, r);  checkOutput("tdr0_bresp", 32'(r), 32'h0);
    @(negedge clk);
    checkOutput("tx0_valid_lit", 32'(fifo_v_o[0]), 32'h1);
    checkOutput("tx0_data_lit", fifo_data_o[0], 32'hA5);
    axilRead(BASE + 32'h0C, d, r);  checkOutput("tdfv0_after1", d, 32'd3);
    axilRead(BASE + 32'h00, d, r);  checkOutput("isr0_set", d, 32'h0800_0000);

    $display("[TB] overfill slot 1 tx fifo then drain");
    for (int k = 0; k < 5; k++) begin
      axilWrite(BASE + 32'h110, 32'h100 + k, r);
      checkOutput("tdr1_bresp", 32'(r), 32'h0);
    end
    axilRead(BASE + 32'h10C, d, r);  checkOutput("tdfv1_full", d, 32'd0);
    @(posedge clk); #1 applyStimulus(2'b10, '0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("drain1_valid", 32'(fifo_v_o[1]), 32'h1);
      checkOutput("drain1_data", fifo_data_o[1], 32'h100 + k);
    end
    @(posedge clk); #1 applyStimulus('0, '0, '0);
    @(negedge clk);
    checkOutput("drain1_empty", 32'(fifo_v_o[1]), 32'h0);

    $display("[TB] fill slot 0 rx fifo and read it back");
    for (int k = 0; k < 4; k++) begin
      applyStimulus('0, 2'b01, {32'h0, 32'hC0DE_0000 + k});
      @(posedge clk); #1;
    end
    applyStimulus('0, '0, '0);
    @(negedge clk);
    checkOutput("rx0_full_ready", 32'(fifo_rdy_o[0]), 32'h0);
    axilRead(BASE + 32'h24, d, r);  checkOutput("rlr0_full", d, 32'd16);
    axilRead(BASE + 32'h1C, d, r);  checkOutput("rdfo0_full", d, 32'd4);
    for (int k = 0; k < 4; k++) begin
      axilRead(BASE + 32'h20, d, r);
      checkOutput("rdr0_data", d, 32'hC0DE_0000 + k);
    end
    axilRead(BASE + 32'h24, d, r);  checkOutput("rlr0_empty", d, 32'd0);

    $display("[TB] ISR write-one-to-clear");
    axilWrite(BASE + 32'h00, 32'h0800_0000, r);  checkOutput("isr_w_bresp", 32'(r), 32'h0);
    axilRead(BASE + 32'h00, d, r);  checkOutput("isr0_cleared", d, 32'h0);
    axilWrite(BASE + 32'h10, 32'h5A, r);
    axilRead(BASE + 32'h00, d, r);  checkOutput("isr0_reset", d, 32'h0800_0000);
    axilRead(BASE + 32'h0C, d, r);  checkOutput("tdfv0_two", d, 32'd2);

    $display("[TB] address decode");
    axilWrite(BASE + 32'h300, 32'h1, r);  checkOutput("bad_w_decerr", 32'(r), 32'h3);
    axilWrite(BASE + 32'h210, 32'h1, r);  checkOutput("mon_w_decerr", 32'(r), 32'h3);
    axilRead(BASE + 32'h300, d, r);
    checkOutput("bad_r_decerr", 32'(r), 32'h3);
    checkOutput("bad_r_data", d, 32'hBEEF_DEAD);
    axilRead(BASE + 32'h2F0, d, r);
    checkOutput("mon_rsp_vac", d, 32'h0000_00AB);
    checkOutput("mon_rsp_okay", 32'(r), 32'h0);
    axilRead(BASE + 32'h2F8, d, r);  checkOutput("mon_credits", d, 32'h0000_0077);
    axilRead(BASE + 32'h2E0, d, r);  checkOutput("mon_rom", d, 32'h1234_5678);
    axilRead(BASE + 32'h044, d, r);  checkOutput("slot_other_ofs", d, 32'hBEEF_DEAD);

    $display("[TB] random traffic");
    for (int k = 0; k < 300; k++) begin
      applyStimulus(N'($urandom), N'($urandom), {$urandom, $urandom});
      slot = $urandom_range(0, N + 1);
      case ($urandom_range(0, 3))
        0, 1: axilWrite(BASE + 32'(slot) * 32'h100 + 32'h10, $urandom, r);
        2:    axilWrite(BASE + 32'(slot) * 32'h100, $urandom, r);
        default: begin
          addr = BASE + 32'(slot) * 32'h100 + 32'(ofs_list[$urandom_range(0, 9)]);
          axilRead(addr, d, r);
        end
      endcase
    end
    applyStimulus('0, '0, '0);
    axilWrite(BASE + 32'h10, 32'h77, r);

    $display("[TB] reset in the middle of a write");
    @(posedge clk); #1;
    bus_i.awaddr = BASE + 32'h10; bus_i.awvalid = 1'b1;
    waitFlag("mid_awready", 0);
    @(posedge clk); #1 bus_i.awvalid = 1'b0;
    @(negedge clk);
    checkOutput("mid_wready", 32'(bus_o.wready), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_wready", 32'(bus_o.wready), 32'h0);
    checkOutput("async_other", {29'b0, bus_o.awready, bus_o.bvalid, bus_o.rvalid}, 32'h0);
    checkOutput("async_tx_valid", 32'(fifo_v_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    axilRead(BASE + 32'h0C, d, r);   checkOutput("post_rst_tdfv0", d, 32'd4);
    axilRead(BASE + 32'h10C, d, r);  checkOutput("post_rst_tdfv1", d, 32'd4);
    axilRead(BASE + 32'h1C, d, r);   checkOutput("post_rst_rdfo0", d, 32'd0);
    axilRead(BASE + 32'h00, d, r);   checkOutput("post_rst_isr0", d, 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
